// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external 1R1W RAM with registered read data.
// A 2-entry skid buffer absorbs the read latency so one word per cycle can flow.
module ram_fifo_ctrl #(
  parameter  int Width      = 8,
  parameter  int Depth      = 512,
  localparam int AddrWidth  = $clog2(Depth),
  localparam int CountWidth = $clog2(Depth + 3)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [Width-1:0]      data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [Width-1:0]      data_o,
  input  logic                  ready_i,
  output logic [CountWidth-1:0] count_o,
  output logic                  ram_wr_valid_o,
  output logic [AddrWidth-1:0]  ram_wr_addr_o,
  output logic [Width-1:0]      ram_wr_data_o,
  output logic                  ram_rd_valid_o,
  output logic [AddrWidth-1:0]  ram_rd_addr_o,
  input  logic [Width-1:0]      ram_rd_data_i
);

  localparam logic [AddrWidth:0] RamFull = (AddrWidth + 1)'(Depth);

  logic [AddrWidth-1:0] r_wr_ptr;
  logic [AddrWidth-1:0] r_rd_ptr;
  logic [AddrWidth:0]   r_ram_cnt;
  logic                 r_inflight;
  logic [1:0]           r_skid_cnt;
  logic [Width-1:0]     r_skid [2];
  logic                 r_skid_rd;
  logic                 r_skid_wr;

  logic w_push;
  logic w_pop;
  logic w_issue;
  logic w_room;

  assign ready_o = (r_ram_cnt != RamFull);
  assign valid_o = (r_skid_cnt != 2'd0);
  assign data_o  = r_skid[r_skid_rd];

  assign w_push = valid_i && ready_o;
  assign w_pop  = valid_o && ready_i;

  // Skid slots not yet claimed by held or in-flight words; a pop frees one this cycle.
  assign w_room  = ({1'b0, r_skid_cnt} + {2'b00, r_inflight}) < 3'd2;
  assign w_issue = (r_ram_cnt != '0) && (w_room || w_pop);

  assign ram_wr_valid_o = w_push;
  assign ram_wr_addr_o  = r_wr_ptr;
  assign ram_wr_data_o  = data_i;
  assign ram_rd_valid_o = w_issue;
  assign ram_rd_addr_o  = r_rd_ptr;

  assign count_o = CountWidth'(r_ram_cnt) + CountWidth'(r_skid_cnt) + CountWidth'(r_inflight);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt  <= r_ram_cnt + (AddrWidth + 1)'(w_push) - (AddrWidth + 1)'(w_issue);
      r_inflight <= w_issue;
    end
  end

  // Skid is a tiny circular FIFO; capture and pop in one cycle leave its count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
      r_skid_rd  <= 1'b0;
      r_skid_wr  <= 1'b0;
      r_skid_cnt <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_skid[r_skid_wr] <= ram_rd_data_i;
        r_skid_wr         <= ~r_skid_wr;
      end
      if (w_pop) r_skid_rd <= ~r_skid_rd;
      r_skid_cnt <= r_skid_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a 512-deep and a 4-deep instance, each with a RAM
// model and a queue-based reference that is compared on every falling edge.
module tb_ram_fifo_ctrl;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- instance A: Depth 512 ----------------
  logic       a_valid_i, a_ready_i, a_ready_o, a_valid_o;
  logic [7:0] a_data_i, a_data_o;
  logic [9:0] a_count;
  logic       a_wr_v, a_rd_v;
  logic [8:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_wr_data, a_rd_data;
  logic [7:0] mem_a [512];

  ram_fifo_ctrl #(.Width(8), .Depth(512)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(a_valid_i), .data_i(a_data_i), .ready_o(a_ready_o),
    .valid_o(a_valid_o), .data_o(a_data_o), .ready_i(a_ready_i),
    .count_o(a_count),
    .ram_wr_valid_o(a_wr_v), .ram_wr_addr_o(a_wr_addr), .ram_wr_data_o(a_wr_data),
    .ram_rd_valid_o(a_rd_v), .ram_rd_addr_o(a_rd_addr), .ram_rd_data_i(a_rd_data)
  );

  always @(posedge clk_i) begin
    if (a_wr_v) mem_a[a_wr_addr] <= a_wr_data;
    if (a_rd_v) a_rd_data <= mem_a[a_rd_addr];
  end

  // ---------------- instance B: Depth 4 ----------------
  logic       b_valid_i, b_ready_i, b_ready_o, b_valid_o;
  logic [7:0] b_data_i, b_data_o;
  logic [2:0] b_count;
  logic       b_wr_v, b_rd_v;
  logic [1:0] b_wr_addr, b_rd_addr;
  logic [7:0] b_wr_data, b_rd_data;
  logic [7:0] mem_b [4];

  ram_fifo_ctrl #(.Width(8), .Depth(4)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .valid_i(b_valid_i), .data_i(b_data_i), .ready_o(b_ready_o),
    .valid_o(b_valid_o), .data_o(b_data_o), .ready_i(b_ready_i),
    .count_o(b_count),
    .ram_wr_valid_o(b_wr_v), .ram_wr_addr_o(b_wr_addr), .ram_wr_data_o(b_wr_data),
    .ram_rd_valid_o(b_rd_v), .ram_rd_addr_o(b_rd_addr), .ram_rd_data_i(b_rd_data)
  );

  always @(posedge clk_i) begin
    if (b_wr_v) mem_b[b_wr_addr] <= b_wr_data;
    if (b_rd_v) b_rd_data <= mem_b[b_rd_addr];
  end

  // Reference: the FIFO is just an ordered list of accepted words.
  logic [7:0] qa [$];
  logic [7:0] qb [$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      qa.delete();
      chk("a_rst_count", 32'(a_count), 0);
      chk("a_rst_valid", 32'(a_valid_o), 0);
      chk("a_rst_ready", 32'(a_ready_o), 1);
      chk("a_rst_rd_en", 32'(a_rd_v), 0);
    end else begin
      chk("a_count", 32'(a_count), qa.size());
      if (a_valid_o) begin
        if (qa.size() == 0) chk("a_valid_when_empty", 32'(a_valid_o), 0);
        else chk("a_data_order", 32'(a_data_o), 32'(qa[0]));
      end
      if (qa.size() < 512) chk("a_ready_below_depth", 32'(a_ready_o), 1);
      if (qa.size() == 514) chk("a_ready_at_capacity", 32'(a_ready_o), 0);
      chk("a_wr_en", 32'(a_wr_v), 32'(a_valid_i && a_ready_o));
      if (a_wr_v) chk("a_wr_data", 32'(a_wr_data), 32'(a_data_i));
      if (a_wr_v && a_rd_v) chk("a_rd_wr_same_addr", 32'(a_rd_addr == a_wr_addr), 0);
      chk("a_skid_bound", 32'(u_a.r_skid_cnt != 2'd3), 1);
      if (a_valid_o && a_ready_i && qa.size() != 0) void'(qa.pop_front());
      if (a_valid_i && a_ready_o) qa.push_back(a_data_i);
    end
  end

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      qb.delete();
      chk("b_rst_count", 32'(b_count), 0);
      chk("b_rst_ready", 32'(b_ready_o), 1);
    end else begin
      chk("b_count", 32'(b_count), qb.size());
      if (b_valid_o) begin
        if (qb.size() == 0) chk("b_valid_when_empty", 32'(b_valid_o), 0);
        else chk("b_data_order", 32'(b_data_o), 32'(qb[0]));
      end
      if (qb.size() < 4) chk("b_ready_below_depth", 32'(b_ready_o), 1);
      if (qb.size() == 6) chk("b_ready_at_capacity", 32'(b_ready_o), 0);
      if (b_wr_v && b_rd_v) chk("b_rd_wr_same_addr", 32'(b_rd_addr == b_wr_addr), 0);
      chk("b_skid_bound", 32'(u_b.r_skid_cnt != 2'd3), 1);
      if (b_valid_o && b_ready_i && qb.size() != 0) void'(qb.pop_front());
      if (b_valid_i && b_ready_o) qb.push_back(b_data_i);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain_a(output int np);
    np = 0;
    a_valid_i = 1'b0;
    a_ready_i = 1'b1;
    for (int c = 0; c < 2000 && a_count != 0; c++) begin
      if (a_valid_o) np++;
      step();
    end
    chk("a_drain_empty", 32'(a_count), 0);
  endtask

  initial begin
    int sent, popped, bub, rdrop, acc, p, n;
    bit seen;
    for (int i = 0; i < 512; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'h00;
    rst_ni = 1'b0;
    a_valid_i = 0; a_ready_i = 0; a_data_i = 0;
    b_valid_i = 0; b_ready_i = 0; b_data_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_ready", 32'(a_ready_o), 1);
    chk("reset_count", 32'(a_count), 0);
    chk("reset_valid", 32'(a_valid_o), 0);
    chk("reset_data", 32'(a_data_o), 0);
    rst_ni = 1'b1;
    step();

    // Reset mid-stream
    a_ready_i = 0;
    for (int i = 0; i < 10; i++) begin
      a_valid_i = 1; a_data_i = 8'(i);
      step();
    end
    a_valid_i = 0;
    chk("fill10_count", 32'(a_count), 10);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_count", 32'(a_count), 0);
    chk("async_rst_valid", 32'(a_valid_o), 0);
    chk("async_rst_ready", 32'(a_ready_o), 1);
    step();
    rst_ni = 1'b1;
    a_valid_i = 1; a_data_i = 8'hA5; a_ready_i = 1;
    step();
    a_valid_i = 0;
    for (int c = 0; c < 10 && !a_valid_o; c++) step();
    chk("post_rst_first_valid", 32'(a_valid_o), 1);
    chk("post_rst_first_data", 32'(a_data_o), 32'hA5);
    step();
    chk("post_rst_empty", 32'(a_count), 0);

    // Single word latency: push at edge N, visible after N+2
    a_valid_i = 1; a_data_i = 8'h3C; a_ready_i = 1;
    step();
    a_valid_i = 0;
    chk("lat_n_valid", 32'(a_valid_o), 0);
    chk("lat_n_count", 32'(a_count), 1);
    step();
    chk("lat_n1_valid", 32'(a_valid_o), 0);
    chk("lat_n1_count", 32'(a_count), 1);
    step();
    chk("lat_n2_valid", 32'(a_valid_o), 1);
    chk("lat_n2_data", 32'(a_data_o), 32'h3C);
    step();
    chk("lat_pop_count", 32'(a_count), 0);
    chk("lat_pop_valid", 32'(a_valid_o), 0);

    // Streaming 1024 words
    sent = 0; popped = 0; bub = 0; rdrop = 0; seen = 0;
    a_ready_i = 1;
    for (int c = 0; c < 1100 && popped < 1024; c++) begin
      a_valid_i = (sent < 1024);
      a_data_i  = sent[7:0];
      if (a_valid_i && !a_ready_o) rdrop++;
      if (a_valid_o) seen = 1;
      else if (seen) bub++;
      if (a_valid_i && a_ready_o) sent++;
      if (a_valid_o && a_ready_i) popped++;
      step();
    end
    a_valid_i = 0;
    chk("stream_popped", 32'(popped), 1024);
    chk("stream_bubbles", 32'(bub), 0);
    chk("stream_ready_drops", 32'(rdrop), 0);

    // Fill to full with consumer stalled
    a_ready_i = 0; acc = 0;
    for (int c = 0; c < 600; c++) begin
      a_valid_i = 1; a_data_i = acc[7:0];
      if (!a_ready_o) break;
      acc++;
      step();
    end
    a_valid_i = 0;
    chk("full_accepted", 32'(acc), 514);
    chk("full_count", 32'(a_count), 514);
    chk("full_ready", 32'(a_ready_o), 0);
    a_ready_i = 1;
    p = a_valid_o ? 1 : 0;
    step();
    chk("full_ready_rise", 32'(a_ready_o), 1);
    chk("full_count_after_pop", 32'(a_count), 513);
    drain_a(n);
    chk("full_drained_words", 32'(p + n), 514);

    // Random backpressure
    for (int c = 0; c < 5000; c++) begin
      a_valid_i = 1'($urandom_range(0, 1));
      a_ready_i = 1'($urandom_range(0, 1));
      a_data_i  = 8'($urandom);
      step();
    end
    drain_a(n);

    // Pointer wrap on the 4-deep instance
    sent = 0; popped = 0;
    for (int c = 0; c < 300 && popped < 20; c++) begin
      b_valid_i = (sent < 20);
      b_data_i  = 8'(8'h40 + sent);
      b_ready_i = c[0];
      if (b_valid_i && b_ready_o) sent++;
      if (b_valid_o && b_ready_i) popped++;
      step();
    end
    b_valid_i = 0; b_ready_i = 0;
    chk("wrap_sent", 32'(sent), 20);
    chk("wrap_popped", 32'(popped), 20);
    chk("wrap_empty", 32'(b_count), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
